// File: rtl/key_loader_if.sv
// Serial key-loading bus between a key source (master) and key_loader (slave).
interface key_loader_if #(
  parameter int KEY_W = 29
) ();
  logic             load_start;
  logic             key_sin;
  logic             key_sin_valid;
  logic [KEY_W-1:0] key_out;
  logic             key_ready;
  logic             key_err;
  logic             busy;
  logic             key_locked;

  modport master (
    output load_start, key_sin, key_sin_valid,
    input  key_out, key_ready, key_err, busy, key_locked
  );

  modport slave (
    input  load_start, key_sin, key_sin_valid,
    output key_out, key_ready, key_err, busy, key_locked
  );
endinterface

// File: rtl/key_loader.sv
// Serial key loader with even-parity check for a logic-locked netlist.
// Define KEY_LOADER_LOCKOUT_EN to lock out after three consecutive parity failures.
module key_loader #(
  parameter int KEY_W = 29,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  key_loader_if.slave  kif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    READY  = 3'd2,
    ERROR  = 3'd3
`ifdef KEY_LOADER_LOCKOUT_EN
    ,
    LOCKED = 3'd4
`endif
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W);

  // True when the key bits plus the parity bit hold an even number of ones.
  function automatic logic even_parity(input logic [KEY_W-1:0] key,
                                       input logic             pbit);
    return ~(^key ^ pbit);
  endfunction

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [KEY_W-1:0] sreg_q;

  logic             start;
  logic             vld_p0;
  logic             last_p0;
  logic             par_ok;
  logic             lock_hit;

  logic [KEY_W-1:0] key_out_c;
  logic             key_ready_c;
  logic             key_err_c;
  logic             busy_c;
  logic             key_locked_c;

`ifdef KEY_LOADER_LOCKOUT_EN
  logic [1:0]       fail_q;

  assign start    = kif.load_start & (state_q != LOCKED);
  assign lock_hit = (fail_q == 2'd2);
`else
  assign start    = kif.load_start;
  assign lock_hit = 1'b0;
`endif

  // A bit is only accepted in SHIFT, and never alongside a (re)start pulse.
  assign vld_p0  = (state_q == SHIFT) & kif.key_sin_valid & ~kif.load_start;
  assign last_p0 = vld_p0 & (cnt_q == CNT_LAST);
  assign par_ok  = even_parity(sreg_q, kif.key_sin);

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, READY, ERROR: begin
        if (kif.load_start) state_d = SHIFT;
      end
      SHIFT: begin
        if (kif.load_start) begin
          state_d = SHIFT;
        end else if (last_p0) begin
          if (par_ok) begin
            state_d = READY;
          end else begin
`ifdef KEY_LOADER_LOCKOUT_EN
            state_d = lock_hit ? LOCKED : ERROR;
`else
            state_d = ERROR;
`endif
          end
        end
      end
`ifdef KEY_LOADER_LOCKOUT_EN
      LOCKED: state_d = LOCKED;
`endif
      default: state_d = IDLE;
    endcase
  end

  // ---- bit counter and shift register ----
  // The counter parks at KEY_W while waiting for the parity bit, so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sreg_q <= '0;
    end else if (start) begin
      cnt_q  <= '0;
      sreg_q <= '0;
    end else if (vld_p0 && (cnt_q != CNT_LAST)) begin
      for (int i = 0; i < KEY_W; i++) begin
        if (cnt_q == CNT_W'(i)) sreg_q[i] <= kif.key_sin;
      end
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef KEY_LOADER_LOCKOUT_EN
  // ---- consecutive-failure counter ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_q <= 2'd0;
    end else if (last_p0) begin
      if (par_ok)               fail_q <= 2'd0;
      else if (fail_q != 2'd3)  fail_q <= fail_q + 2'd1;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = lock_hit;
`endif

  // ---- output decode ----
  // key_out is gated to zero outside READY so the netlist never sees a partial key.
  always_comb begin
    key_out_c    = '0;
    key_ready_c  = 1'b0;
    key_err_c    = 1'b0;
    busy_c       = 1'b0;
    key_locked_c = 1'b0;
    case (state_q)
      SHIFT: busy_c = 1'b1;
      READY: begin
        key_out_c   = sreg_q;
        key_ready_c = 1'b1;
      end
      ERROR: key_err_c = 1'b1;
`ifdef KEY_LOADER_LOCKOUT_EN
      LOCKED: begin
        key_err_c    = 1'b1;
        key_locked_c = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign kif.key_out    = key_out_c;
  assign kif.key_ready  = key_ready_c;
  assign kif.key_err    = key_err_c;
  assign kif.busy       = busy_c;
  assign kif.key_locked = key_locked_c;

endmodule
